uart_rx: RTL and testbench

Receive half of the UART link: deserialises an 8N1 asynchronous line into bytes, with the same bit timing as our `uart_tx`. It sits on the external `rx` pin and feeds received bytes to the uartmaster command logic through a valid/ack holding register. It also flags framing errors and overruns. Start-bit glitches are rejected by a mid-bit re-check.

---
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous receiver with a mid-bit start re-check, framing
// error pulse, break handling and a valid/ack holding register with overrun.
// Bit timing matches uart_tx: one bit lasts TICK+1 clocks.
//
// Output handshake: o_valid is a level that rises when a byte is delivered
// and stays high, with o_dat frozen, until the consumer pulses i_ack while
// o_valid=1. i_ack is ignored while o_valid=0. A delivery in the same cycle
// as i_ack replaces the byte and keeps o_valid high; a delivery while a byte
// is still pending without i_ack overwrites it and raises o_overrun, which
// is cleared by the next plain ack.
module uart_rx #(
  parameter int unsigned TICK = 21
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       rx,
  output logic [7:0] o_dat,
  output logic       o_valid,
  input  logic       i_ack,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy,
  output logic [2:0] o_dbg_state
);

  localparam logic [8:0] TICK_C = 9'(TICK);
  localparam logic [8:0] HALF_C = 9'(TICK / 2);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    WAITHIGH = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rx_s_q, rx_s_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  dat_q, dat_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        busy_q, busy_d;
  logic        deliver;
  logic        rx_s;

  // Only the second synchroniser stage is ever looked at by the FSM.
  assign rx_s = rx_s_q;

  // Next-state logic: synchroniser, frame FSM, counters and holding register.
  always_comb begin
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q + 9'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 9'd0;
        if (!rx_s) begin
          state_d = START;
        end
      end
      START: begin
        // Re-check the line half a bit in; a high level means a glitch.
        if (cnt_q == HALF_C) begin
          cnt_d     = 9'd0;
          bit_idx_d = 3'd0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == TICK_C) begin
          cnt_d   = 9'd0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q == TICK_C) begin
          cnt_d = 9'd0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAITHIGH;
          end
        end
      end
      WAITHIGH: begin
        // A held-low line (break) must not restart reception until it idles.
        cnt_d = 9'd0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = 9'd0;
        state_d = IDLE;
      end
    endcase

    dat_d     = dat_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (deliver) begin
      dat_d   = shift_q;
      valid_d = 1'b1;
      if (valid_q && !i_ack) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && i_ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset wins over everything, even mid-frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= 9'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      dat_q       <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      dat_q       <= dat_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign o_dat       = dat_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = busy_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with TICK=21 (22 clocks per bit, HALF=10).
module tb_uart_rx;

  localparam int BIT = 22;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAITHIGH = 3'd4;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       rx;
  logic       i_ack;
  logic [7:0] o_dat;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;
  logic [2:0] o_dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_p = 0;

  // Event monitors, sampled on the falling edge.
  int vrise_cnt = 0;
  int ferr_hi_cnt = 0;
  int ferr_cyc = 0;
  int busy_hi_cnt = 0;
  logic prev_v = 1'b0;

  int base_v, base_f, base_b;

  uart_rx #(.TICK(21)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .rx          (rx),
    .o_dat       (o_dat),
    .o_valid     (o_valid),
    .i_ack       (i_ack),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy),
    .o_dbg_state (o_dbg_state)
  );

  // Clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_v <= o_valid;
    if (o_valid === 1'b1 && prev_v !== 1'b1) vrise_cnt <= vrise_cnt + 1;
    if (o_frame_err === 1'b1) begin
      ferr_hi_cnt <= ferr_hi_cnt + 1;
      ferr_cyc    <= cyc;
    end
    if (o_busy === 1'b1) busy_hi_cnt <= busy_hi_cnt + 1;
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d limit=50000", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one 8N1 frame; call #1 after a rising edge. Line is left at the
  // stop-bit level. Edge p (first edge seeing the low) is recorded in last_p.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    last_p = cyc + 1;
    repeat (BIT) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    i_ack = 1'b1;
    @(posedge clk);
    #1;
    i_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    i_reset = 1'b1;
    rx      = 1'b1;
    i_ack   = 1'b0;
    idle(3);
    check("rst_dat", o_dat, 8'h00);
    check("rst_valid", o_valid, 1'b0);
    check("rst_ferr", o_frame_err, 1'b0);
    check("rst_overrun", o_overrun, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_state", o_dbg_state, S_IDLE);
    i_reset = 1'b0;
    idle(5);

    // Loopback 0xA5: o_valid rises exactly at edge p+211
    base_f = ferr_hi_cnt;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        idle(211);
        check("lb_valid_p210", o_valid, 1'b0);
        idle(1);
        check("lb_valid_p211", o_valid, 1'b1);
        check("lb_dat", o_dat, 8'hA5);
        check("lb_busy_after_stop", o_busy, 1'b0);
        ack_pulse();
        check("lb_valid_after_ack", o_valid, 1'b0);
      end
    join
    check("lb_no_ferr", ferr_hi_cnt - base_f, 0);
    idle(5);

    // Glitch: low for 5 clocks
    base_v = vrise_cnt; base_f = ferr_hi_cnt; base_b = busy_hi_cnt;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(30);
    check("gl_busy_cycles", busy_hi_cnt - base_b, 11);
    check("gl_no_valid", vrise_cnt - base_v, 0);
    check("gl_no_ferr", ferr_hi_cnt - base_f, 0);
    check("gl_state", o_dbg_state, S_IDLE);

    // Framing error then break
    base_v = vrise_cnt; base_f = ferr_hi_cnt;
    send_frame(8'h3C, 1'b0);
    check("fe_pulses", ferr_hi_cnt - base_f, 1);
    check("fe_cycle", ferr_cyc, last_p + 211);
    check("fe_no_valid", vrise_cnt - base_v, 0);
    check("fe_state_wh", o_dbg_state, S_WAITHIGH);
    idle(500);
    check("brk_state_wh", o_dbg_state, S_WAITHIGH);
    check("brk_busy", o_busy, 1'b1);
    check("brk_no_more_ferr", ferr_hi_cnt - base_f, 1);
    rx = 1'b1;
    idle(3);
    check("brk_release_idle", o_dbg_state, S_IDLE);
    idle(5);
    send_frame(8'h81, 1'b1);
    check("brk_next_valid", vrise_cnt - base_v, 1);
    check("brk_next_dat", o_dat, 8'h81);
    check("brk_total_ferr", ferr_hi_cnt - base_f, 1);
    ack_pulse();
    idle(5);

    // Overrun: 0x11 then 0x22 back-to-back without ack
    send_frame(8'h11, 1'b1);
    check("ov_first_dat", o_dat, 8'h11);
    check("ov_first_overrun", o_overrun, 1'b0);
    send_frame(8'h22, 1'b1);
    check("ov_dat", o_dat, 8'h22);
    check("ov_valid", o_valid, 1'b1);
    check("ov_overrun", o_overrun, 1'b1);
    ack_pulse();
    check("ov_ack_valid", o_valid, 1'b0);
    check("ov_ack_overrun", o_overrun, 1'b0);
    idle(5);

    // Ack on the exact delivery cycle of 0x22 while 0x11 pending
    send_frame(8'h11, 1'b1);
    check("col_pending", o_valid, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        idle(211);
        check("col_old_dat", o_dat, 8'h11);
        ack_pulse();
        check("col_dat", o_dat, 8'h22);
        check("col_valid", o_valid, 1'b1);
        check("col_overrun", o_overrun, 1'b0);
      end
    join
    ack_pulse();
    check("col_cleared", o_valid, 1'b0);
    idle(5);

    // Reset during data bit 4 of 0xFF with 0x33 pending
    send_frame(8'h33, 1'b1);
    check("rm_pending", o_dat, 8'h33);
    base_v = vrise_cnt; base_f = ferr_hi_cnt;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(119);
        i_reset = 1'b1;
        idle(1);
        i_reset = 1'b0;
        check("rm_dat", o_dat, 8'h00);
        check("rm_valid", o_valid, 1'b0);
        check("rm_overrun", o_overrun, 1'b0);
        check("rm_ferr", o_frame_err, 1'b0);
        check("rm_busy", o_busy, 1'b0);
        check("rm_state", o_dbg_state, S_IDLE);
      end
    join
    idle(10);
    check("rm_no_byte", vrise_cnt - base_v, 0);
    check("rm_no_ferr", ferr_hi_cnt - base_f, 0);
    check("rm_state_after", o_dbg_state, S_IDLE);
    send_frame(8'h5A, 1'b1);
    check("rm_next_valid", vrise_cnt - base_v, 1);
    check("rm_next_dat", o_dat, 8'h5A);
    ack_pulse();
    check("rm_next_ack", o_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
